ysyx_22040759_ifu: RTL and testbench

Instruction fetch unit directly upstream of the `ysyx_22040759_npc` single-cycle core. Takes the core's `pc_out` as the next fetch address and fetches that word from instruction memory over a valid/ready request and valid response handshake. Holds the instruction stable on `inst` with a valid flag until the core commits. Substitutes a NOP and raises an error flag on misaligned fetch, bus error or response timeout.

---
 rtl/ysyx_22040759_ifu_if.sv | 28 ++
 rtl/ysyx_22040759_ifu.sv | 90 +++++++++
 tb/tb_ysyx_22040759_ifu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_ifu_if.sv
// Instruction memory bus between the fetch unit and imem.
// Request is valid/ready; response is a single valid-qualified beat.
interface ysyx_22040759_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );
endinterface

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: fetches one word per committed pc and holds it
// for the core, substituting a NOP on misalignment, bus error or timeout.
module ysyx_22040759_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc_in,
    input  logic                 pc_update,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic                 fetch_err,
    output logic [31:0]          fetch_count,
    ysyx_22040759_ifu_if.master  imem
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] fetch_addr;
    logic [31:0] inst_r;
    logic [7:0]  tcnt;
    logic        err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            fetch_addr  <= RESET_PC;
            inst_r      <= NOP_INST;
            tcnt        <= 8'd0;
            err_r       <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            unique case (state)
                S_REQ: begin
                    // misaligned pc never reaches the bus
                    if (fetch_addr[1:0] != 2'b00) begin
                        state       <= S_HOLD;
                        inst_r      <= NOP_INST;
                        err_r       <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                    end else if (imem.imem_req_ready) begin
                        state <= S_WAIT;
                        tcnt  <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        state       <= S_HOLD;
                        inst_r      <= imem.imem_rsp_err ? NOP_INST
                                                         : imem.imem_rsp_data;
                        err_r       <= imem.imem_rsp_err;
                        fetch_count <= fetch_count + 32'd1;
                    end else if (tcnt == TCNT_LAST) begin
                        state       <= S_HOLD;
                        inst_r      <= NOP_INST;
                        err_r       <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (pc_update) begin
                        state      <= S_REQ;
                        fetch_addr <= pc_in;
                        inst_r     <= NOP_INST;
                        err_r      <= 1'b0;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    assign inst                = inst_r;
    assign inst_valid          = (state == S_HOLD);
    assign fetch_err           = (state == S_HOLD) && err_r;
    assign imem.imem_addr      = fetch_addr;
    assign imem.imem_req_valid = (state == S_REQ) && (fetch_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// Randomized fetch bench with a per-fetch outcome/latency reference model.
// A behavioural imem grants after a chosen stall and answers after a chosen delay.
module tb_ysyx_22040759_ifu;

    localparam int          T   = 8;
    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = 32'd0;
    logic        pc_update = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
    logic [31:0] fetch_count;

    ysyx_22040759_ifu_if bus ();

    ysyx_22040759_ifu #(
        .RESET_PC (RPC),
        .NOP_INST (NOP),
        .TIMEOUT  (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_update   (pc_update),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count),
        .imem        (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          exp_count = 0;
    int          m_stall = 0;
    int          m_delay = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_data = 32'd0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // imem model: m_delay==0 means the request is never answered
    initial begin
        int          pend;
        logic [31:0] pd;
        bit          pe;
        pend = 0;
        pd = 32'd0;
        pe = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err   = 1'($urandom);
            bus.imem_rsp_data  = $urandom;
            if (rst) begin
                pend = 0;
                bus.imem_req_ready = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.imem_rsp_valid = 1'b1;
                        bus.imem_rsp_data  = pd;
                        bus.imem_rsp_err   = pe;
                    end
                end
                if (bus.imem_req_valid) begin
                    if (m_stall > 0) begin
                        bus.imem_req_ready = 1'b0;
                        m_stall--;
                    end else begin
                        bus.imem_req_ready = 1'b1;
                        pend = m_delay;
                        pd   = m_data;
                        pe   = m_err;
                    end
                end else begin
                    bus.imem_req_ready = 1'($urandom);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int s, input int d,
                         input bit e, input logic [31:0] w,
                         input bit after_rst);
        bit          mis;
        bit          bad;
        int          lat;
        int          k;
        bit          got;
        logic [31:0] ei;
        logic [31:0] hold_inst;
        mis = (a[1:0] != 2'b00);
        bad = mis || e || d == 0 || d > T;
        ei  = bad ? NOP : w;
        lat = mis ? 2 : 2 + s + ((d == 0 || d > T) ? T : d);
        if (after_rst) lat--;
        m_stall = s;
        m_delay = d;
        m_err   = e;
        m_data  = w;
        if (after_rst) begin
            rst = 1'b0;
            check("first_req", 32'(bus.imem_req_valid), 32'd1);
            check("first_addr", bus.imem_addr, a);
        end else begin
            pc_in     = a;
            pc_update = 1'b1;
        end
        k = 0;
        got = 1'b0;
        while (k < lat + 6 && !got) begin
            @(negedge clk);
            k++;
            if (inst_valid) begin
                got = 1'b1;
            end else begin
                check("pre_nop", inst, NOP);
                check("pre_err", 32'(fetch_err), 32'd0);
                if (mis)
                    check("mis_noreq", 32'(bus.imem_req_valid), 32'd0);
                else if (bus.imem_req_valid)
                    check("req_addr", bus.imem_addr, a);
                pc_update = 1'($urandom);
                pc_in     = $urandom;
            end
        end
        pc_update = 1'b0;
        exp_count++;
        check("latency", 32'(k), 32'(lat));
        check("inst", inst, ei);
        check("fetch_err", 32'(fetch_err), 32'(bad));
        check("count", fetch_count, 32'(exp_count));
        hold_inst = inst;
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            check("hold_valid", 32'(inst_valid), 32'd1);
            check("hold_inst", inst, hold_inst);
            check("hold_count", fetch_count, 32'(exp_count));
        end
    endtask

    initial begin
        logic [31:0] a;
        int          d;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, NOP);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_addr", bus.imem_addr, RPC);

        fetch(RPC, 0, 1, 1'b0, 32'h0010_0093, 1'b1);
        fetch(32'h8000_0004, 4, 1, 1'b0, $urandom, 1'b0);
        fetch(32'h8000_0006, 0, 1, 1'b0, $urandom, 1'b0);
        fetch(32'h8000_0008, 0, 2, 1'b1, $urandom, 1'b0);
        fetch(32'h8000_000c, 1, 0, 1'b0, $urandom, 1'b0);
        fetch(32'h8000_0010, 0, T + 1, 1'b0, $urandom, 1'b0);
        fetch(32'h8000_0014, 0, T, 1'b0, $urandom, 1'b0);

        // reset while a fetch is outstanding
        m_stall   = 0;
        m_delay   = 0;
        pc_in     = 32'h9000_0000;
        pc_update = 1'b1;
        repeat (2) begin
            @(negedge clk);
            pc_update = 1'($urandom);
            pc_in     = $urandom;
        end
        rst = 1'b1;
        pc_update = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_count", fetch_count, 32'd0);
        check("mid_rst_addr", bus.imem_addr, RPC);
        exp_count = 0;
        fetch(RPC, 1, 2, 1'b0, $urandom, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, T + 1);
            fetch(a, $urandom_range(0, 3), d, ($urandom_range(0, 3) == 0),
                  $urandom, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
